sw_hw_io_handshake: RTL and testbench

Hardware-side endpoint of the software-to-hardware mailbox between the CPU's PIO registers and the rendering logic.
- Software pushes 9-bit words one at a time using a 2-bit request/acknowledge handshake.
- The block collects the words into a write bank of a ping-pong buffer.
- On commit it swaps banks, so the renderer always reads a complete, stable frame through a random-access read port.

---
 rtl/sw_hw_io_handshake.sv | 143 ++++++++++++++
 tb/tb_sw_hw_io_handshake.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sw_hw_io_handshake.sv
// Purpose: HW endpoint of the SW->HW PIO mailbox; collects words into a ping-pong frame buffer (opt. macro IO_INPUT_SYNC_EN).
// Latency: a request sampled at edge N is acked on to_sw_sig after edge N (+2 cycles with IO_INPUT_SYNC_EN); rd_data is combinational.
// Backpressure: SW must wait for to_sw_sig!=0 and then drop to 0; a full write bank acks with code 3 and drops the word.
module sw_hw_io_handshake #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic [1:0]        to_hw_sig,
  input  logic [DATA_W-1:0] to_hw_data,
  output logic [1:0]        to_sw_sig,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [AW:0]       frame_len,
  output logic              frame_valid
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ACK_DATA   = 2'd1,
    ACK_COMMIT = 2'd2,
    ACK_ERR    = 2'd3
  } state_t;

  localparam logic [AW:0] PTR_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  logic [1:0]        req_sig;
  logic [DATA_W-1:0] req_data;

`ifdef IO_INPUT_SYNC_EN
  logic [1:0]        sig_meta_q, sig_meta_d, sig_sync_q, sig_sync_d;
  logic [DATA_W-1:0] data_meta_q, data_meta_d, data_sync_q, data_sync_d;

  // Next values of the two-stage input synchronizers.
  always_comb begin
    sig_meta_d  = to_hw_sig;
    sig_sync_d  = sig_meta_q;
    data_meta_d = to_hw_data;
    data_sync_d = data_meta_q;
  end

  // Two-flop synchronizers for the software-driven request and data.
  always_ff @(posedge clk50) begin
    if (!reset) begin
      sig_meta_q  <= '0;
      sig_sync_q  <= '0;
      data_meta_q <= '0;
      data_sync_q <= '0;
    end else begin
      sig_meta_q  <= sig_meta_d;
      sig_sync_q  <= sig_sync_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
    end
  end

  assign req_sig  = sig_sync_q;
  assign req_data = data_sync_q;
`else
  assign req_sig  = to_hw_sig;
  assign req_data = to_hw_data;
`endif

  state_t            state_q, state_d;
  logic [AW:0]       ptr_q, ptr_d;
  logic [AW:0]       frame_len_q, frame_len_d;
  logic              bank_sel_q, bank_sel_d;
  logic              frame_valid_q, frame_valid_d;
  logic              wr_en;
  logic [DATA_W-1:0] mem_q [2][DEPTH];

  // Handshake FSM: act once on each idle->request transition, then hold the ack until SW returns to 0.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    frame_len_d   = frame_len_q;
    bank_sel_d    = bank_sel_q;
    frame_valid_d = 1'b0;
    wr_en         = 1'b0;
    case (state_q)
      IDLE: begin
        case (req_sig)
          2'd1: begin
            if (ptr_q == PTR_FULL) begin
              state_d = ACK_ERR;
            end else begin
              wr_en   = 1'b1;
              ptr_d   = ptr_q + PTR_ONE;
              state_d = ACK_DATA;
            end
          end
          2'd2: begin
            frame_len_d   = ptr_q;
            bank_sel_d    = ~bank_sel_q;
            ptr_d         = '0;
            frame_valid_d = 1'b1;
            state_d       = ACK_COMMIT;
          end
          2'd3: begin
            ptr_d   = '0;
            state_d = ACK_ERR;
          end
          default: state_d = IDLE;
        endcase
      end
      default: begin
        // Any nonzero code while acknowledging is the same request still held.
        if (req_sig == 2'd0) state_d = IDLE;
      end
    endcase
  end

  // Control state registers; reset discards any partial frame.
  always_ff @(posedge clk50) begin
    if (!reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      frame_len_q   <= '0;
      bank_sel_q    <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      frame_len_q   <= frame_len_d;
      bank_sel_q    <= bank_sel_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  // Word write into the bank software is filling; the display bank is never written.
  always_ff @(posedge clk50) begin
    if (reset && wr_en) mem_q[bank_sel_q][ptr_q[AW-1:0]] <= req_data;
  end

  assign to_sw_sig   = state_q;
  assign frame_len   = frame_len_q;
  assign frame_valid = frame_valid_q;
  assign rd_data     = mem_q[~bank_sel_q][rd_addr];

endmodule

// File: tb/tb_sw_hw_io_handshake.sv
// Testbench for sw_hw_io_handshake (default build, inputs used directly).
// Table-driven vectors for the basic handshake, plus directed multi-cycle sequences.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_sw_hw_io_handshake;

  logic       clk50;
  logic       reset;
  logic [1:0] to_hw_sig;
  logic [8:0] to_hw_data;
  logic [1:0] to_sw_sig;
  logic [3:0] rd_addr;
  logic [8:0] rd_data;
  logic [4:0] frame_len;
  logic       frame_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int fv_seen = 0;

  sw_hw_io_handshake dut (
    .clk50      (clk50),
    .reset      (reset),
    .to_hw_sig  (to_hw_sig),
    .to_hw_data (to_hw_data),
    .to_sw_sig  (to_sw_sig),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_len  (frame_len),
    .frame_valid(frame_valid)
  );

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  typedef struct {
    logic [1:0] sig;
    logic [8:0] data;
    logic [3:0] addr;
    logic [1:0] e_sw;
    logic       e_fv;
    logic [4:0] e_len;
    logic       chk_rd;
    logic [8:0] e_rd;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk50);
      #1;
      fv_seen += int'(frame_valid);
    end
  endtask

  task automatic drive(input logic [1:0] s, input logic [8:0] d, input int n);
    to_hw_sig  = s;
    to_hw_data = d;
    step(n);
  endtask

  initial begin
    // sig, data, addr, exp sw, exp fv, exp len, check rd, exp rd
    vecs[0]  = '{2'd1, 9'h1A5, 4'd0, 2'd1, 1'b0, 5'd0, 1'b0, 9'h000};
    vecs[1]  = '{2'd0, 9'h000, 4'd0, 2'd0, 1'b0, 5'd0, 1'b0, 9'h000};
    vecs[2]  = '{2'd2, 9'h000, 4'd0, 2'd2, 1'b1, 5'd1, 1'b1, 9'h1A5};
    vecs[3]  = '{2'd2, 9'h000, 4'd0, 2'd2, 1'b0, 5'd1, 1'b1, 9'h1A5};
    vecs[4]  = '{2'd0, 9'h000, 4'd0, 2'd0, 1'b0, 5'd1, 1'b1, 9'h1A5};
    vecs[5]  = '{2'd1, 9'h055, 4'd0, 2'd1, 1'b0, 5'd1, 1'b1, 9'h1A5};
    vecs[6]  = '{2'd1, 9'h0AA, 4'd0, 2'd1, 1'b0, 5'd1, 1'b1, 9'h1A5};
    vecs[7]  = '{2'd0, 9'h000, 4'd0, 2'd0, 1'b0, 5'd1, 1'b0, 9'h000};
    vecs[8]  = '{2'd1, 9'h0BB, 4'd0, 2'd1, 1'b0, 5'd1, 1'b1, 9'h1A5};
    vecs[9]  = '{2'd0, 9'h000, 4'd0, 2'd0, 1'b0, 5'd1, 1'b0, 9'h000};
    vecs[10] = '{2'd2, 9'h000, 4'd0, 2'd2, 1'b1, 5'd2, 1'b1, 9'h055};
    vecs[11] = '{2'd0, 9'h000, 4'd1, 2'd0, 1'b0, 5'd2, 1'b1, 9'h0BB};

    reset = 1'b0; to_hw_sig = 2'd0; to_hw_data = 9'h000; rd_addr = 4'd0;
    step(2);
    chk("reset_sw", 32'(to_sw_sig), 32'd0);
    chk("reset_len", 32'(frame_len), 32'd0);
    chk("reset_fv", 32'(frame_valid), 32'd0);
    reset = 1'b1;

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 12; i++) begin
      rd_addr = vecs[i].addr;
      drive(vecs[i].sig, vecs[i].data, 1);
      chk($sformatf("vec%0d_sw", i), 32'(to_sw_sig), 32'(vecs[i].e_sw));
      chk($sformatf("vec%0d_fv", i), 32'(frame_valid), 32'(vecs[i].e_fv));
      chk($sformatf("vec%0d_len", i), 32'(frame_len), 32'(vecs[i].e_len));
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd", i), 32'(rd_data), 32'(vecs[i].e_rd));
    end

    // Alternating stream: 12 single-word frames, 4 cycles per level.
    rd_addr = 4'd0;
    for (int i = 0; i < 12; i++) begin
      drive(2'd1, 9'(i), 4);
      drive(2'd0, 9'h000, 4);
      fv_seen = 0;
      drive(2'd2, 9'h000, 4);
      chk($sformatf("stream%0d_sw", i), 32'(to_sw_sig), 32'd2);
      chk($sformatf("stream%0d_pulses", i), 32'(fv_seen), 32'd1);
      chk($sformatf("stream%0d_len", i), 32'(frame_len), 32'd1);
      chk($sformatf("stream%0d_rd", i), 32'(rd_data), 32'(i));
      drive(2'd0, 9'h000, 4);
    end

    // Overflow: 16 words fill the bank, the 17th is refused.
    for (int k = 0; k < 16; k++) begin
      drive(2'd1, 9'(9'h100 + k), 2);
      if (k == 15) chk("ovf_last_ack", 32'(to_sw_sig), 32'd1);
      drive(2'd0, 9'h000, 2);
    end
    drive(2'd1, 9'h1FF, 2);
    chk("ovf_17_sw", 32'(to_sw_sig), 32'd3);
    chk("ovf_17_len", 32'(frame_len), 32'd1);
    drive(2'd0, 9'h000, 2);
    chk("ovf_release_sw", 32'(to_sw_sig), 32'd0);
    fv_seen = 0;
    drive(2'd2, 9'h000, 1);
    chk("ovf_commit_fv", 32'(frame_valid), 32'd1);
    chk("ovf_commit_len", 32'(frame_len), 32'd16);
    drive(2'd2, 9'h000, 1);
    drive(2'd0, 9'h000, 2);
    chk("ovf_commit_pulses", 32'(fv_seen), 32'd1);
    for (int k = 0; k < 16; k++) begin
      rd_addr = 4'(k);
      #1;
      chk($sformatf("ovf_rd%0d", k), 32'(rd_data), 32'(9'h100 + k));
    end

    // Abort discards 3 words; display frame untouched.
    rd_addr = 4'd0;
    for (int k = 0; k < 3; k++) begin
      drive(2'd1, 9'(9'h0C0 + k), 2);
      drive(2'd0, 9'h000, 2);
    end
    drive(2'd3, 9'h000, 1);
    chk("abort_sw", 32'(to_sw_sig), 32'd3);
    chk("abort_len", 32'(frame_len), 32'd16);
    chk("abort_rd", 32'(rd_data), 32'h100);
    drive(2'd0, 9'h000, 2);
    chk("abort_release_sw", 32'(to_sw_sig), 32'd0);

    // Glitch: data request held, then switched straight to commit.
    drive(2'd1, 9'h1EE, 2);
    chk("glitch_data_sw", 32'(to_sw_sig), 32'd1);
    fv_seen = 0;
    drive(2'd2, 9'h0DD, 2);
    chk("glitch_commit_sw", 32'(to_sw_sig), 32'd1);
    chk("glitch_no_commit", 32'(fv_seen), 32'd0);
    chk("glitch_len", 32'(frame_len), 32'd16);
    drive(2'd0, 9'h000, 2);
    drive(2'd2, 9'h000, 1);
    chk("glitch_commit2_sw", 32'(to_sw_sig), 32'd2);
    chk("glitch_commit2_len", 32'(frame_len), 32'd1);
    chk("glitch_commit2_rd", 32'(rd_data), 32'h1EE);
    drive(2'd0, 9'h000, 2);

    // Reset in the middle of a data acknowledge.
    drive(2'd1, 9'h033, 1);
    chk("midrst_pre_sw", 32'(to_sw_sig), 32'd1);
    reset = 1'b0;
    step(1);
    chk("midrst_sw", 32'(to_sw_sig), 32'd0);
    chk("midrst_len", 32'(frame_len), 32'd0);
    chk("midrst_fv", 32'(frame_valid), 32'd0);
    to_hw_sig = 2'd0;
    step(1);
    reset = 1'b1;
    step(1);
    drive(2'd2, 9'h000, 1);
    chk("midrst_commit_sw", 32'(to_sw_sig), 32'd2);
    chk("midrst_commit_fv", 32'(frame_valid), 32'd1);
    chk("midrst_commit_len", 32'(frame_len), 32'd0);
    drive(2'd0, 9'h000, 2);
    chk("midrst_end_sw", 32'(to_sw_sig), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
